// File: rtl/column_reduce_acc_if.sv
// ---------------------------------------------------------------------------
// column_reduce_acc_if
// Purpose : bundles the beat handshake, the fifteen weighted column bit-heaps
//           and the group-result outputs of column_reduce_acc.
// Signals : in_valid/in_first/in_last - beat strobe and group markers
//           O0..O14                   - column bits, column k has weight 2^k
//           out_valid/out_acc/out_sat - completed group result and overflow flag
//           err_restart               - group restarted before its last beat
// Modports: master drives beats and reads results, slave is the reducer.
// ---------------------------------------------------------------------------
interface column_reduce_acc_if #(
    parameter int ACC_W = 32
);
    logic                    in_valid;
    logic                    in_first;
    logic                    in_last;
    logic [8:0]              O14;
    logic [8:0]              O13;
    logic [17:0]             O12;
    logic [17:0]             O11;
    logic [35:0]             O10;
    logic [35:0]             O9;
    logic [35:0]             O8;
    logic [35:0]             O7;
    logic [44:0]             O6;
    logic [26:0]             O5;
    logic [35:0]             O4;
    logic [17:0]             O3;
    logic [26:0]             O2;
    logic [8:0]              O1;
    logic [17:0]             O0;
    logic                    out_valid;
    logic signed [ACC_W-1:0] out_acc;
    logic                    out_sat;
    logic                    err_restart;

    modport master (
        output in_valid, in_first, in_last,
        output O14, O13, O12, O11, O10, O9, O8, O7, O6, O5, O4, O3, O2, O1, O0,
        input  out_valid, out_acc, out_sat, err_restart
    );

    modport slave (
        input  in_valid, in_first, in_last,
        input  O14, O13, O12, O11, O10, O9, O8, O7, O6, O5, O4, O3, O2, O1, O0,
        output out_valid, out_acc, out_sat, err_restart
    );
endinterface

// File: rtl/column_reduce_acc.sv
// ---------------------------------------------------------------------------
// column_reduce_acc
// Purpose : reduces the fifteen weighted column bit-heaps of the Booth
//           partial-product stage to one signed dot-product per beat, then
//           accumulates the beats of a kernel group and emits the group sum.
//           Three register stages: popcount, weighted sum, accumulate.
// Ports   : clk     - clock, all state on the rising edge
//           reset_n - synchronous active-low reset
//           io_bus  - column_reduce_acc_if slave modport (beats in, results out)
// Params  : SUM_W - per-beat dot-product width (column sum mod 2^SUM_W, signed)
//           ACC_W - accumulator and result width, must exceed SUM_W
//           SAT   - 1 clamps the accumulator at full scale, 0 wraps
// ---------------------------------------------------------------------------
module column_reduce_acc #(
    parameter int SUM_W = 16,
    parameter int ACC_W = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    column_reduce_acc_if.slave    io_bus
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        GRP_IDLE,
        GRP_OPEN
    } grpState_t;

    function automatic logic [5:0] popCount(input logic [44:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 45; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    logic [5:0]              w_cnt [15];
    logic [5:0]              r_cnt [15];
    logic                    r_s1Valid;
    logic                    r_s1First;
    logic                    r_s1Last;

    logic [SUM_W-1:0]        w_beatSum;
    logic signed [SUM_W-1:0] r_beat;
    logic                    r_s2Valid;
    logic                    r_s2First;
    logic                    r_s2Last;

    grpState_t               r_state;
    grpState_t               w_stateNext;
    logic [ACC_W-1:0]        r_acc;
    logic                    r_groupSat;
    logic [ACC_W-1:0]        w_beatExt;
    logic [ACC_W:0]          w_sumWide;
    logic                    w_ovf;
    logic [ACC_W-1:0]        w_addResult;
    logic [ACC_W-1:0]        w_accNext;
    logic                    w_satNext;
    logic                    w_emit;
    logic                    w_err;

    logic                    r_outValid;
    logic [ACC_W-1:0]        r_outAcc;
    logic                    r_outSat;
    logic                    r_errRestart;

    // Column populations; narrower columns are zero-extended to a common width.
    always_comb begin
        w_cnt[0]  = popCount(45'(io_bus.O0));
        w_cnt[1]  = popCount(45'(io_bus.O1));
        w_cnt[2]  = popCount(45'(io_bus.O2));
        w_cnt[3]  = popCount(45'(io_bus.O3));
        w_cnt[4]  = popCount(45'(io_bus.O4));
        w_cnt[5]  = popCount(45'(io_bus.O5));
        w_cnt[6]  = popCount(io_bus.O6);
        w_cnt[7]  = popCount(45'(io_bus.O7));
        w_cnt[8]  = popCount(45'(io_bus.O8));
        w_cnt[9]  = popCount(45'(io_bus.O9));
        w_cnt[10] = popCount(45'(io_bus.O10));
        w_cnt[11] = popCount(45'(io_bus.O11));
        w_cnt[12] = popCount(45'(io_bus.O12));
        w_cnt[13] = popCount(45'(io_bus.O13));
        w_cnt[14] = popCount(45'(io_bus.O14));
    end

    // Stage 1: register column counts; group markers only mean something with a valid beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1Valid <= 1'b0;
            r_s1First <= 1'b0;
            r_s1Last  <= 1'b0;
            for (int k = 0; k < 15; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_s1Valid <= io_bus.in_valid;
            r_s1First <= io_bus.in_valid & io_bus.in_first;
            r_s1Last  <= io_bus.in_valid & io_bus.in_last;
            r_cnt     <= w_cnt;
        end
    end

    // Weighted column sum built directly at SUM_W bits, so the carry out of the
    // top bit is discarded and the result is the sum modulo 2^SUM_W.
    always_comb begin
        w_beatSum = '0;
        for (int k = 0; k < 15; k++) begin
            w_beatSum = w_beatSum + (SUM_W'(r_cnt[k]) << k);
        end
    end

    // Stage 2: hold the beat as a signed dot-product.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_beat    <= '0;
            r_s2Valid <= 1'b0;
            r_s2First <= 1'b0;
            r_s2Last  <= 1'b0;
        end else begin
            r_beat    <= signed'(w_beatSum);
            r_s2Valid <= r_s1Valid;
            r_s2First <= r_s1First;
            r_s2Last  <= r_s1Last;
        end
    end

    // Accumulate with one guard bit; overflow shows as the guard bit disagreeing
    // with the sign bit, and the guard bit gives the true sign for clamping.
    always_comb begin
        w_beatExt   = ACC_W'(r_beat);
        w_sumWide   = {r_acc[ACC_W-1], r_acc} + {w_beatExt[ACC_W-1], w_beatExt};
        w_ovf       = w_sumWide[ACC_W] ^ w_sumWide[ACC_W-1];
        w_addResult = w_sumWide[ACC_W-1:0];
        if (SAT && w_ovf) begin
            w_addResult = w_sumWide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Group tracker: a first beat always restarts (flagging a dropped open group),
    // continuation beats only count while a group is open, last closes and emits.
    always_comb begin
        w_stateNext = r_state;
        w_accNext   = r_acc;
        w_satNext   = r_groupSat;
        w_emit      = 1'b0;
        w_err       = 1'b0;
        if (r_s2Valid) begin
            if (r_s2First) begin
                w_accNext   = w_beatExt;
                w_satNext   = 1'b0;
                w_err       = (r_state == GRP_OPEN);
                w_emit      = r_s2Last;
                w_stateNext = r_s2Last ? GRP_IDLE : GRP_OPEN;
            end else if (r_state == GRP_OPEN) begin
                w_accNext = w_addResult;
                w_satNext = r_groupSat | w_ovf;
                w_emit    = r_s2Last;
                if (r_s2Last) begin
                    w_stateNext = GRP_IDLE;
                end
            end
        end
    end

    // Stage 3: accumulator state and registered outputs; results hold between pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= GRP_IDLE;
            r_acc        <= '0;
            r_groupSat   <= 1'b0;
            r_outValid   <= 1'b0;
            r_outAcc     <= '0;
            r_outSat     <= 1'b0;
            r_errRestart <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_acc        <= w_accNext;
            r_groupSat   <= w_satNext;
            r_outValid   <= w_emit;
            r_errRestart <= w_err;
            if (w_emit) begin
                r_outAcc <= w_accNext;
                r_outSat <= w_satNext;
            end
        end
    end

    assign io_bus.out_valid   = r_outValid;
    assign io_bus.out_acc     = r_outAcc;
    assign io_bus.out_sat     = r_outSat;
    assign io_bus.err_restart = r_errRestart;

endmodule

// File: tb/tb_column_reduce_acc.sv
// ---------------------------------------------------------------------------
// tb_column_reduce_acc
// Purpose : drives three reducers (32-bit saturating, 18-bit saturating,
//           18-bit wrapping) with identical directed beats and compares every
//           cycle against a group-level arithmetic model.
// ---------------------------------------------------------------------------
module tb_column_reduce_acc;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    column_reduce_acc_if #(.ACC_W(32)) ifA ();
    column_reduce_acc_if #(.ACC_W(18)) ifB ();
    column_reduce_acc_if #(.ACC_W(18)) ifC ();

    column_reduce_acc #(.SUM_W(16), .ACC_W(32), .SAT(1'b1)) dutA (
        .clk(clk), .reset_n(reset_n), .io_bus(ifA.slave)
    );
    column_reduce_acc #(.SUM_W(16), .ACC_W(18), .SAT(1'b1)) dutB (
        .clk(clk), .reset_n(reset_n), .io_bus(ifB.slave)
    );
    column_reduce_acc #(.SUM_W(16), .ACC_W(18), .SAT(1'b0)) dutC (
        .clk(clk), .reset_n(reset_n), .io_bus(ifC.slave)
    );

    // Shared stimulus fanned out to all three interfaces.
    logic        vValid;
    logic        vFirst;
    logic        vLast;
    logic [44:0] vCol [15];

    assign ifA.in_valid = vValid; assign ifA.in_first = vFirst; assign ifA.in_last = vLast;
    assign ifB.in_valid = vValid; assign ifB.in_first = vFirst; assign ifB.in_last = vLast;
    assign ifC.in_valid = vValid; assign ifC.in_first = vFirst; assign ifC.in_last = vLast;
    assign ifA.O0 = vCol[0][17:0];  assign ifB.O0 = vCol[0][17:0];  assign ifC.O0 = vCol[0][17:0];
    assign ifA.O1 = vCol[1][8:0];   assign ifB.O1 = vCol[1][8:0];   assign ifC.O1 = vCol[1][8:0];
    assign ifA.O2 = vCol[2][26:0];  assign ifB.O2 = vCol[2][26:0];  assign ifC.O2 = vCol[2][26:0];
    assign ifA.O3 = vCol[3][17:0];  assign ifB.O3 = vCol[3][17:0];  assign ifC.O3 = vCol[3][17:0];
    assign ifA.O4 = vCol[4][35:0];  assign ifB.O4 = vCol[4][35:0];  assign ifC.O4 = vCol[4][35:0];
    assign ifA.O5 = vCol[5][26:0];  assign ifB.O5 = vCol[5][26:0];  assign ifC.O5 = vCol[5][26:0];
    assign ifA.O6 = vCol[6];        assign ifB.O6 = vCol[6];        assign ifC.O6 = vCol[6];
    assign ifA.O7 = vCol[7][35:0];  assign ifB.O7 = vCol[7][35:0];  assign ifC.O7 = vCol[7][35:0];
    assign ifA.O8 = vCol[8][35:0];  assign ifB.O8 = vCol[8][35:0];  assign ifC.O8 = vCol[8][35:0];
    assign ifA.O9 = vCol[9][35:0];  assign ifB.O9 = vCol[9][35:0];  assign ifC.O9 = vCol[9][35:0];
    assign ifA.O10 = vCol[10][35:0]; assign ifB.O10 = vCol[10][35:0]; assign ifC.O10 = vCol[10][35:0];
    assign ifA.O11 = vCol[11][17:0]; assign ifB.O11 = vCol[11][17:0]; assign ifC.O11 = vCol[11][17:0];
    assign ifA.O12 = vCol[12][17:0]; assign ifB.O12 = vCol[12][17:0]; assign ifC.O12 = vCol[12][17:0];
    assign ifA.O13 = vCol[13][8:0];  assign ifB.O13 = vCol[13][8:0];  assign ifC.O13 = vCol[13][8:0];
    assign ifA.O14 = vCol[14][8:0];  assign ifB.O14 = vCol[14][8:0];  assign ifC.O14 = vCol[14][8:0];

    int   cyc = 0;
    logic rstSeen;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rstSeen <= !reset_n;
    end

    // Expected result of one accepted beat, due at the DUT outputs on cycle 'due'.
    typedef struct {
        int     due;
        bit     outV;
        bit     err;
        longint acc0;
        longint acc1;
        longint acc2;
        bit [2:0] sat;
    } ev_t;

    ev_t    pend[$];
    int     accW [3]    = '{32, 18, 18};
    bit     satMode [3] = '{1'b1, 1'b1, 1'b0};
    bit     mOpen;
    longint mAcc [3];
    bit     mSat [3];
    longint heldAcc [3];
    bit     heldSat [3];
    int     checks = 0;
    int     errors = 0;
    int     validSeen = 0;
    int     errSeen = 0;
    bit     checking = 1'b0;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Dot-product of one beat straight from the column populations.
    function automatic longint beatOf(input int c [15]);
        longint s;
        s = 0;
        for (int k = 0; k < 15; k++) begin
            s = s + longint'(c[k]) * (longint'(1) << k);
        end
        s = s % 65536;
        if (s >= 32768) s = s - 65536;
        return s;
    endfunction

    function automatic longint wrapTo(input longint t, input int w);
        longint m;
        m = longint'(1) << w;
        t = t % m;
        if (t < 0) t = t + m;
        if (t >= m / 2) t = t - m;
        return t;
    endfunction

    task automatic modelBeat(input bit first, input bit last, input int c [15]);
        ev_t    ev;
        longint b;
        longint t;
        longint hi;
        longint lo;
        bit     handled;
        b       = beatOf(c);
        ev.due  = cyc + 3;
        ev.outV = 1'b0;
        ev.err  = 1'b0;
        handled = first || mOpen;
        if (first) begin
            ev.err = mOpen;
            mOpen  = 1'b1;
            for (int i = 0; i < 3; i++) begin
                mAcc[i] = b;
                mSat[i] = 1'b0;
            end
        end else if (mOpen) begin
            for (int i = 0; i < 3; i++) begin
                hi = (longint'(1) << (accW[i] - 1)) - 1;
                lo = -(longint'(1) << (accW[i] - 1));
                t  = mAcc[i] + b;
                if (t > hi || t < lo) begin
                    mSat[i] = 1'b1;
                    if (satMode[i]) t = (t > hi) ? hi : lo;
                    else            t = wrapTo(t, accW[i]);
                end
                mAcc[i] = t;
            end
        end
        if (last && handled) begin
            ev.outV = 1'b1;
            mOpen   = 1'b0;
        end
        ev.acc0 = mAcc[0];
        ev.acc1 = mAcc[1];
        ev.acc2 = mAcc[2];
        ev.sat  = {mSat[2], mSat[1], mSat[0]};
        pend.push_back(ev);
    endtask

    function automatic longint dutAcc(input int i);
        case (i)
            0:       return longint'(ifA.out_acc);
            1:       return longint'(ifB.out_acc);
            default: return longint'(ifC.out_acc);
        endcase
    endfunction

    function automatic logic [2:0] dutFlags(input int i);
        case (i)
            0:       return {ifA.out_valid, ifA.err_restart, ifA.out_sat};
            1:       return {ifB.out_valid, ifB.err_restart, ifB.out_sat};
            default: return {ifC.out_valid, ifC.err_restart, ifC.out_sat};
        endcase
    endfunction

    // Per-cycle comparison of all three DUTs against the model.
    always @(negedge clk) begin
        bit         expV;
        bit         expE;
        ev_t        ev;
        logic [2:0] f;
        if (checking) begin
            expV = 1'b0;
            expE = 1'b0;
            if (rstSeen) begin
                pend.delete();
                for (int i = 0; i < 3; i++) begin
                    heldAcc[i] = 0;
                    heldSat[i] = 1'b0;
                end
            end else if (pend.size() > 0 && pend[0].due == cyc) begin
                ev   = pend.pop_front();
                expV = ev.outV;
                expE = ev.err;
                if (ev.outV) begin
                    heldAcc[0] = ev.acc0;
                    heldAcc[1] = ev.acc1;
                    heldAcc[2] = ev.acc2;
                    heldSat[0] = ev.sat[0];
                    heldSat[1] = ev.sat[1];
                    heldSat[2] = ev.sat[2];
                end
            end
            for (int i = 0; i < 3; i++) begin
                f = dutFlags(i);
                checkOutput($sformatf("out_valid[dut%0d]", i), longint'(f[2]), longint'(expV));
                checkOutput($sformatf("err_restart[dut%0d]", i), longint'(f[1]), longint'(expE));
                checkOutput($sformatf("out_sat[dut%0d]", i), longint'(f[0]), longint'(heldSat[i]));
                checkOutput($sformatf("out_acc[dut%0d]", i), dutAcc(i), heldAcc[i]);
            end
            if (ifA.out_valid === 1'b1)   validSeen++;
            if (ifA.err_restart === 1'b1) errSeen++;
        end
    end

    task automatic applyStimulus(input bit valid, input bit first, input bit last, input int c [15]);
        @(posedge clk);
        #2;
        vValid = valid;
        vFirst = first;
        vLast  = last;
        for (int k = 0; k < 15; k++) begin
            vCol[k] = (45'(1) << c[k]) - 45'(1);
        end
        if (valid) modelBeat(first, last, c);
    endtask

    task automatic idle(input int n);
        int z [15];
        z = '{default: 0};
        for (int j = 0; j < n; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, z);
        end
    endtask

    task automatic doReset(input int n);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        vValid  = 1'b0;
        mOpen   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mAcc[i] = 0;
            mSat[i] = 1'b0;
        end
        repeat (n) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        int c [15];
        int v0;
        int e0;
        reset_n = 1'b0;
        vValid  = 1'b0;
        vFirst  = 1'b0;
        vLast   = 1'b0;
        mOpen   = 1'b0;
        for (int k = 0; k < 15; k++) vCol[k] = '0;
        for (int i = 0; i < 3; i++) begin
            mAcc[i] = 0; mSat[i] = 1'b0; heldAcc[i] = 0; heldSat[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        checking = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle(2);

        // Single-beat group: 3 ones at weight 1 plus 2 ones at weight 4.
        c = '{default: 0}; c[0] = 3; c[2] = 2;
        applyStimulus(1'b1, 1'b1, 1'b1, c);
        idle(5);
        $display("[TB] single beat group");
        checkOutput("t1_acc_dut", longint'(ifA.out_acc), 11);
        checkOutput("t1_acc_model", heldAcc[0], 11);

        // Column sum wrapping at 16 bits and reading back as signed.
        c = '{default: 0}; c[13] = 9; c[14] = 9;
        applyStimulus(1'b1, 1'b1, 1'b1, c);
        idle(5);
        checkOutput("t2_wrap_dut", longint'(ifA.out_acc), 24576);
        checkOutput("t2_wrap_model", heldAcc[0], 24576);
        c = '{default: 0}; c[14] = 2;
        applyStimulus(1'b1, 1'b1, 1'b1, c);
        idle(5);
        checkOutput("t2_neg_dut", longint'(ifA.out_acc), -32768);
        checkOutput("t2_neg_model", heldAcc[0], -32768);

        // Four one-beats separated by two-cycle bubbles.
        v0 = validSeen;
        c = '{default: 0}; c[0] = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, c); idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, c); idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, c); idle(2);
        applyStimulus(1'b1, 1'b0, 1'b1, c);
        idle(5);
        checkOutput("t3_acc_dut", longint'(ifA.out_acc), 4);
        checkOutput("t3_pulses", longint'(validSeen - v0), 1);

        // Nine beats of +16384: clamp vs wrap in the 18-bit accumulators.
        c = '{default: 0}; c[14] = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, c);
        for (int j = 0; j < 7; j++) applyStimulus(1'b1, 1'b0, 1'b0, c);
        applyStimulus(1'b1, 1'b0, 1'b1, c);
        idle(5);
        checkOutput("t4_sat_acc", longint'(ifB.out_acc), 131071);
        checkOutput("t4_sat_flag", longint'(ifB.out_sat), 1);
        checkOutput("t4_wrap_acc", longint'(ifC.out_acc), -114688);
        checkOutput("t4_wrap_flag", longint'(ifC.out_sat), 1);
        checkOutput("t4_wide_acc", longint'(ifA.out_acc), 147456);
        checkOutput("t4_wide_flag", longint'(ifA.out_sat), 0);

        // Six beats of -32768: negative clamp and wrap.
        c = '{default: 0}; c[14] = 2;
        applyStimulus(1'b1, 1'b1, 1'b0, c);
        for (int j = 0; j < 4; j++) applyStimulus(1'b1, 1'b0, 1'b0, c);
        applyStimulus(1'b1, 1'b0, 1'b1, c);
        idle(5);
        checkOutput("t7_negsat_acc", longint'(ifB.out_acc), -131072);
        checkOutput("t7_negwrap_acc", longint'(ifC.out_acc), 65536);
        checkOutput("t7_wide_acc", longint'(ifA.out_acc), -196608);

        // Restart while a group is open.
        e0 = errSeen;
        c = '{default: 0}; c[0] = 5;
        applyStimulus(1'b1, 1'b1, 1'b0, c);
        c = '{default: 0}; c[0] = 1;
        applyStimulus(1'b1, 1'b1, 1'b1, c);
        idle(5);
        checkOutput("t5_err_pulses", longint'(errSeen - e0), 1);
        checkOutput("t5_acc_dut", longint'(ifA.out_acc), 1);

        // Back-to-back groups at full rate, then stray beats with no open group.
        c = '{default: 0}; c[1] = 4; c[6] = 3;
        applyStimulus(1'b1, 1'b1, 1'b1, c);
        c = '{default: 0}; c[5] = 27; c[3] = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, c);
        c = '{default: 0}; c[7] = 36; c[12] = 18;
        applyStimulus(1'b1, 1'b0, 1'b0, c);
        c = '{default: 0}; c[4] = 36; c[9] = 2;
        applyStimulus(1'b1, 1'b0, 1'b1, c);
        c = '{default: 0}; c[0] = 9;
        applyStimulus(1'b1, 1'b0, 1'b0, c);
        applyStimulus(1'b1, 1'b0, 1'b1, c);
        idle(5);

        // Reset mid-group discards it; the following last-only beat is stray.
        v0 = validSeen;
        c = '{default: 0}; c[0] = 2;
        applyStimulus(1'b1, 1'b1, 1'b0, c);
        c = '{default: 0}; c[0] = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, c);
        idle(4);
        doReset(1);
        c = '{default: 0}; c[0] = 7;
        applyStimulus(1'b1, 1'b0, 1'b1, c);
        idle(6);
        checkOutput("t6_no_pulse", longint'(validSeen - v0), 0);
        checkOutput("t6_acc_cleared", longint'(ifA.out_acc), 0);

        checkOutput("pending_drained", longint'(pend.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
